log2_stream: RTL and testbench
==============================

Name: log2_stream

Overview:
- Streaming fixed-point log2 stage in the cepstrum datapath.
- Sits between the power-spectrum stage (|X[k]|^2, unsigned) and the inverse-FFT input.
- Computes log2 of each input sample by leading-one detection and normalisation, followed by a two-port lookup into the external log2 LUT block (entries log2(i), i=1..DEPTH-1; entry 0 = -100 in fixed point) and linear interpolation.
- Valid/ready on both sides; frame marker passed through.

Parameters:
- IN_WIDTH, 32, unsigned input sample width.
- WIDTH, 16, signed output / LUT entry width (two's complement).
- BP, 8, fractional bits of output and LUT entries.
- DEPTH, 32, LUT entries; power of two, >= 4.
- IDX_W, $clog2(DEPTH), LUT index width (derived; not overridden).
- FRAC_W, 8, interpolation fraction width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  stage can accept a sample
- in_data  in  IN_WIDTH  unsigned power sample
- in_last  in  1  last sample of frame
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  signed log2(in_data), Q(WIDTH-BP).BP
- out_last  out  1  in_last delayed with its sample
- lut_index0  out  IDX_W  LUT read address, lower point
- lut_index1  out  IDX_W  LUT read address, upper point
- lut_out0  in  WIDTH  LUT data for lut_index0 (combinational)
- lut_out1  in  WIDTH  LUT data for lut_index1 (combinational)
- zero_count  out  16  saturating count of zero-valued input samples

Behaviour:
- Reset (async assert, sync-style deassert): all stage valids 0, out_valid=0, out_data=0, out_last=0, zero_count=0, lut_index0/1=0. in_ready=1 after reset.
- Three-stage pipeline, latency 3 cycles with out_ready held high; throughput 1 sample per cycle.
- A stage advances when its downstream stage is empty or advancing. in_ready = !s1_valid | s1_advance.
- Output is held stable while out_valid & !out_ready.
- Stage 1 (normalise):
  - p = index of the leading one of in_data.
  - If p >= IDX_W-1: e = p-(IDX_W-1); m = in_data>>e, so m is in [DEPTH/2, DEPTH-1]; the e bits below m are left-aligned into FRAC_W (truncated, or zero-padded if e < FRAC_W) to form frac.
  - Else: e=0, m=in_data, frac=0.
  - in_data==0: zero flag set; zero_count increments, saturating at 0xFFFF.
- Stage 2 (lookup):
  - lut_index0 = m.
  - lut_index1 = m+1, or m when m==DEPTH-1 or frac==0.
  - Register lut_out0 and lut_out1, together with e, frac, zero flag and last.
- Stage 3 (interpolate):
  - upper = IDX_W<<BP when m==DEPTH-1, else lut_out1.
  - diff = upper - lut_out0, computed WIDTH+1 signed.
  - interp = lut_out0 + ((diff*frac)>>>FRAC_W).
  - result = interp + (e<<BP), computed in WIDTH+IDX_W+2 bits, saturated to the signed WIDTH range.
  - Zero flag set: result = lut_out0 (the sentinel), no exponent add, no interpolation.
- in_last travels with its sample; no frame-level state.
- Simultaneous in and out handshakes in the same cycle: accepted with no bubble.
- Reset mid-frame: in-flight samples are discarded.

Optional Feature:
- Macro: LOG2_STREAM_INTERP_EN.
- Defined: linear interpolation as above.
- Undefined:
  - lut_index1 = lut_index0 always; lut_out1 is ignored.
  - result = lut_out0 + (e<<BP), i.e. mantissa truncation.
  - The frac datapath and multiplier are removed.
  - Latency and handshakes are unchanged.

Decomposition:
- Package log2_pkg holds:
  - sentinel constant LOG2_ZERO = -100<<BP;
  - the saturating-add function;
  - the result struct (data, last).
- One sub-module: lzd_norm, combinational leading-one detect and normalise (outputs e, m, frac, zero).
- Interpolation and saturation stay in the top level.

Test Plan:
- Stream x=1,16,32,48,0 with out_ready=1 -> outputs 0, 1024, 1280, 1430, -25600, each 3 cycles after acceptance; zero_count=1.
- x=49 (interp on) -> m=24, frac=0x80, lut[24]=1174, lut[25]=1189 -> out_data=1437; with LOG2_STREAM_INTERP_EN undefined -> 1430.
- x=0xFFFFFFFF -> m=31, e=27, frac=0xFF, upper=1280, lut[31]=1268 -> out_data=8191; lut_index1=31.
- Random out_ready toggling over a 64-sample frame -> no loss or duplication; out_data/out_last stable while stalled; out_last only on sample 64.
- 70000 zero inputs -> zero_count saturates at 65535; every output equals -25600.
- Assert reset_n low with 3 samples in flight -> out_valid drops immediately, zero_count=0; first post-reset sample emerges with latency 3.

Source files
------------

// File: rtl/log2_pkg.sv
// log2_pkg: shared sentinel, saturating add and output record for log2_stream.
package log2_pkg;
  localparam int LOG2_BP = 8;
  localparam int LOG2_W = 16;
  localparam logic signed [LOG2_W-1:0] LOG2_ZERO = LOG2_W'(-100 * (1 << LOG2_BP));
  typedef struct packed {
    logic signed [LOG2_W-1:0] data;
    logic last;
  } log2_res_t;
  function automatic longint sat_add(input longint a, input longint b, input int w);
    longint s, hi, lo;
    s = a + b;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return s > hi ? hi : (s < lo ? lo : s);
  endfunction
endpackage

// File: rtl/log2_stream_lzd_norm.sv
// lzd_norm: leading-one detect and normalise of an unsigned sample into exponent, LUT mantissa and fraction.
// The fraction output exists only when LOG2_STREAM_INTERP_EN is defined.
module lzd_norm #(
  parameter int IN_WIDTH = 32,
  parameter int IDX_W = 5,
  parameter int E_W = 5
`ifdef LOG2_STREAM_INTERP_EN
  , parameter int FRAC_W = 8
`endif
) (
  input logic [IN_WIDTH-1:0] x,
  output logic [E_W-1:0] e,
  output logic [IDX_W-1:0] m,
`ifdef LOG2_STREAM_INTERP_EN
  output logic [FRAC_W-1:0] frac,
`endif
  output logic zero
);
  localparam logic [E_W-1:0] PMIN = E_W'(IDX_W - 1);
  logic [E_W-1:0] p;
  always_comb begin
    p = '0;
    for (int i = 0; i < IN_WIDTH; i++) p = x[i] ? E_W'(i) : p;
  end
  assign zero = x == '0;
  assign e = p >= PMIN ? p - PMIN : '0;
  assign m = IDX_W'(x >> e);
`ifdef LOG2_STREAM_INTERP_EN
  localparam int EW1 = E_W + 1;
  logic [E_W:0] amt;
  // Shift the e bits below the mantissa up to the MSB, then keep the top FRAC_W of them.
  assign amt = EW1'(IN_WIDTH) - {1'b0, e};
  assign frac = FRAC_W'((x << amt) >> (IN_WIDTH - FRAC_W));
`endif
endmodule

// File: rtl/log2_stream.sv
// log2_stream: streaming fixed-point log2 via normalise, dual LUT lookup and linear interpolation.
// Interpolation is built only when LOG2_STREAM_INTERP_EN is defined; otherwise the mantissa is truncated.
module log2_stream
  import log2_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int WIDTH = LOG2_W,
  parameter int BP = LOG2_BP,
  parameter int DEPTH = 32,
  parameter int FRAC_W = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input logic clock,
  input logic reset_n,
  input logic in_valid,
  output logic in_ready,
  input logic [IN_WIDTH-1:0] in_data,
  input logic in_last,
  output logic out_valid,
  input logic out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic out_last,
  output logic [IDX_W-1:0] lut_index0,
  output logic [IDX_W-1:0] lut_index1,
  input logic signed [WIDTH-1:0] lut_out0,
  input logic signed [WIDTH-1:0] lut_out1,
  output logic [15:0] zero_count
);
  localparam int E_W = $clog2(IN_WIDTH);
  localparam int RW = WIDTH + IDX_W + 2;
  logic [E_W-1:0] n_e, s1_e, s2_e;
  logic [IDX_W-1:0] n_m, s1_m;
  logic n_zero, s1_zero, s2_zero;
  logic s1_valid, s2_valid, s1_last, s2_last;
  logic s3_ready, s2_ready, s2_adv, s1_adv, in_acc;
  logic signed [WIDTH-1:0] s2_lo;
  logic signed [RW-1:0] interp, ebias;
  log2_res_t res, res_q;
  logic unused_in;
`ifdef LOG2_STREAM_INTERP_EN
  localparam int DW = WIDTH + 1;
  localparam logic signed [WIDTH-1:0] UPPER_TOP = WIDTH'(IDX_W << BP);
  logic [FRAC_W-1:0] n_frac, s1_frac, s2_frac;
  logic s2_top;
  logic signed [WIDTH-1:0] s2_hi, upper;
  logic signed [WIDTH:0] diff;
  logic signed [WIDTH+FRAC_W+1:0] prod;
`endif
  lzd_norm #(
    .IN_WIDTH(IN_WIDTH),
    .IDX_W(IDX_W),
    .E_W(E_W)
`ifdef LOG2_STREAM_INTERP_EN
    , .FRAC_W(FRAC_W)
`endif
  ) u_lzd (
    .x(in_data),
    .e(n_e),
    .m(n_m),
`ifdef LOG2_STREAM_INTERP_EN
    .frac(n_frac),
`endif
    .zero(n_zero)
  );
  assign s3_ready = !out_valid | out_ready;
  assign s2_ready = !s2_valid | s3_ready;
  assign s2_adv = s2_valid & s3_ready;
  assign s1_adv = s1_valid & s2_ready;
  assign in_ready = !s1_valid | s1_adv;
  assign in_acc = in_valid & in_ready;
  assign lut_index0 = s1_m;
  assign ebias = $signed(RW'(s2_e) << BP);
`ifdef LOG2_STREAM_INTERP_EN
  assign unused_in = 1'b0;
  assign lut_index1 = (s1_m == IDX_W'(DEPTH - 1) || s1_frac == '0) ? s1_m : s1_m + 1'b1;
  always_comb begin
    upper = s2_top ? UPPER_TOP : s2_hi;
    diff = DW'(upper) - DW'(s2_lo);
    prod = diff * $signed({1'b0, s2_frac});
    interp = RW'(s2_lo) + RW'(prod >>> FRAC_W);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      s1_frac <= '0;
      s2_frac <= '0;
      s2_hi <= '0;
      s2_top <= 1'b0;
    end else begin
      if (in_acc) s1_frac <= n_frac;
      if (s1_adv) begin
        s2_frac <= s1_frac;
        s2_hi <= lut_out1;
        s2_top <= s1_m == IDX_W'(DEPTH - 1);
      end
    end
`else
  assign unused_in = ^{lut_out1, FRAC_W[0]};
  assign lut_index1 = s1_m;
  assign interp = RW'(s2_lo);
`endif
  // A zero sample passes the LUT sentinel through untouched.
  always_comb begin
    res.last = s2_last;
    res.data = s2_zero ? s2_lo : WIDTH'(sat_add(longint'(interp), longint'(ebias), WIDTH));
  end
  assign out_data = res_q.data;
  assign out_last = res_q.last;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_e <= '0;
      s1_m <= '0;
      s1_zero <= 1'b0;
      s1_last <= 1'b0;
      s2_valid <= 1'b0;
      s2_e <= '0;
      s2_zero <= 1'b0;
      s2_last <= 1'b0;
      s2_lo <= '0;
      out_valid <= 1'b0;
      res_q <= '0;
      zero_count <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_acc) begin
        s1_e <= n_e;
        s1_m <= n_m;
        s1_zero <= n_zero;
        s1_last <= in_last;
      end
      if (in_acc && n_zero && zero_count != 16'hFFFF) zero_count <= zero_count + 1'b1;
      if (s2_ready) s2_valid <= s1_valid;
      if (s1_adv) begin
        s2_e <= s1_e;
        s2_zero <= s1_zero;
        s2_last <= s1_last;
        s2_lo <= lut_out0;
      end
      if (s3_ready) out_valid <= s2_valid;
      if (s2_adv) res_q <= res;
    end
endmodule

// File: tb/tb_log2_stream.sv
// tb_log2_stream: scoreboard bench for log2_stream; honours LOG2_STREAM_INTERP_EN like the RTL.
module tb_log2_stream;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready;
  logic signed [15:0] out_data;
  logic out_last;
  logic [4:0] lut_index0, lut_index1;
  logic signed [15:0] lut_out0, lut_out1;
  logic [15:0] zero_count;
  logic fix_rdy = 1'b1;
  logic rand_rdy = 1'b0;
  logic rnd_rdy = 1'b1;
  logic lat_chk = 1'b1;
  logic stall_prev = 1'b0;
  logic prev_l = 1'b0;
  logic signed [15:0] prev_d = '0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_seen = 0;
  int obs[$];
  typedef struct {
    int d;
    logic l;
    int c;
  } exp_t;
  exp_t sb[$];
  exp_t it;
  int lut[32] = '{-25600, 0, 256, 406, 512, 594, 662, 719, 768, 812, 850, 886, 918, 947, 975, 1000,
                  1024, 1046, 1068, 1087, 1106, 1124, 1142, 1158, 1174, 1189, 1203, 1217, 1231, 1244, 1256, 1268};

  assign lut_out0 = 16'(lut[lut_index0]);
  assign lut_out1 = 16'(lut[lut_index1]);
  assign out_ready = rand_rdy ? rnd_rdy : fix_rdy;

  log2_stream dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .lut_index0(lut_index0), .lut_index1(lut_index1), .lut_out0(lut_out0), .lut_out1(lut_out1),
    .zero_count(zero_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int model(input logic [31:0] x);
    int p, e, m, fr, r;
    logic [31:0] low;
    if (x == 0) return -25600;
    p = 0;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    e = p > 4 ? p - 4 : 0;
    m = int'(x >> e);
    low = x & ((32'd1 << e) - 32'd1);
    fr = e >= 8 ? int'(low >> (e - 8)) : int'(low << (8 - e));
    r = lut[m];
`ifdef LOG2_STREAM_INTERP_EN
    r = r + (((m == 31 ? 1280 : lut[m == 31 ? 31 : m + 1]) - r) * fr >>> 8);
`endif
    r = r + e * 256;
    return r > 32767 ? 32767 : (r < -32768 ? -32768 : r);
  endfunction

  always @(negedge clock) begin
    if (!reset_n) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        n_cmp++;
        if (!out_valid || out_data !== prev_d || out_last !== prev_l) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", out_valid, out_data, out_last, prev_d, prev_l);
        end
      end
      if (out_valid && out_ready) begin
        obs.push_back(int'(out_data));
        if (out_last) last_seen++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_extra: got d=%0d with nothing expected", out_data);
        end else begin
          it = sb.pop_front();
          if (out_data !== 16'(it.d) || out_last !== it.l) begin
            n_bad++;
            $display("FAIL sb_data: got d=%0d l=%0b want d=%0d l=%0b", out_data, out_last, 16'(it.d), it.l);
          end
          if (lat_chk) begin
            n_cmp++;
            if (cyc - it.c != 3) begin
              n_bad++;
              $display("FAIL latency: got %0d want 3", cyc - it.c);
            end
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{model(in_data), in_last, cyc});
      stall_prev = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  task automatic send(input logic [31:0] x, input logic l);
    int t = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_data = x;
    in_last = l;
    while (!acc) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      t++;
      if (!acc && t > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got no accept want accept within 1000 cycles");
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp += 5;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%0b d=%0d l=%0b want 0 0 0", out_valid, out_data, out_last);
    end
    if (zero_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_zc: got %0d want 0", zero_count);
    end
    if (lut_index0 !== 5'd0 || lut_index1 !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_idx: got %0d/%0d want 0/0", lut_index0, lut_index1);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %0b want 1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid_after: got %0b want 0", out_valid);
    end
  endtask

  task automatic test_basic();
    int want[5] = '{0, 1024, 1280, 1430, -25600};
    logic [31:0] xs[5] = '{32'd1, 32'd16, 32'd32, 32'd48, 32'd0};
    obs.delete();
    for (int i = 0; i < 5; i++) send(xs[i], i == 4);
    drain();
    n_cmp++;
    if (obs.size() != 5) begin
      n_bad++;
      $display("FAIL basic_count: got %0d want 5", obs.size());
    end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] != want[i]) begin
        n_bad++;
        $display("FAIL basic_val%0d: got %0d want %0d", i, obs[i], want[i]);
      end
    end
    n_cmp++;
    if (zero_count !== 16'd1) begin
      n_bad++;
      $display("FAIL basic_zc: got %0d want 1", zero_count);
    end
  endtask

  task automatic test_interp();
`ifdef LOG2_STREAM_INTERP_EN
    int w49 = 1437, wmax = 8191, i49 = 25;
`else
    int w49 = 1430, wmax = 8180, i49 = 24;
`endif
    obs.delete();
    send(32'd49, 1'b0);
    n_cmp++;
    if (lut_index0 !== 5'd24 || int'(lut_index1) != i49) begin
      n_bad++;
      $display("FAIL idx49: got %0d/%0d want 24/%0d", lut_index0, lut_index1, i49);
    end
    send(32'hFFFF_FFFF, 1'b1);
    n_cmp++;
    if (lut_index0 !== 5'd31 || lut_index1 !== 5'd31) begin
      n_bad++;
      $display("FAIL idxmax: got %0d/%0d want 31/31", lut_index0, lut_index1);
    end
    drain();
    n_cmp++;
    if (obs.size() != 2 || obs[0] != w49 || obs[1] != wmax) begin
      n_bad++;
      $display("FAIL interp_vals: got n=%0d %0d %0d want %0d %0d", obs.size(), obs.size() > 0 ? obs[0] : 0, obs.size() > 1 ? obs[1] : 0, w49, wmax);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    obs.delete();
    t0 = cyc;
    for (int i = 0; i < 16; i++) send(32'(i * 1000 + 7), i == 15);
    n_cmp++;
    if (cyc - t0 != 16) begin
      n_bad++;
      $display("FAIL b2b_cycles: got %0d want 16", cyc - t0);
    end
    drain();
    n_cmp++;
    if (obs.size() != 16) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want 16", obs.size());
    end
  endtask

  task automatic test_stall();
    obs.delete();
    lat_chk = 1'b0;
    fix_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(32'(300 + i * 77), i == 2);
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_full: got rdy=%0b v=%0b want rdy=0 v=1", in_ready, out_valid);
    end
    repeat (4) @(posedge clock);
    #1;
    fix_rdy = 1'b1;
    drain();
    lat_chk = 1'b1;
    n_cmp++;
    if (obs.size() != 3) begin
      n_bad++;
      $display("FAIL stall_count: got %0d want 3", obs.size());
    end
  endtask

  task automatic test_backpressure();
    obs.delete();
    last_seen = 0;
    lat_chk = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
      send(($urandom_range(0, 7) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 31), i == 63);
    end
    drain();
    rand_rdy = 1'b0;
    lat_chk = 1'b1;
    n_cmp += 2;
    if (obs.size() != 64) begin
      n_bad++;
      $display("FAIL bp_count: got %0d want 64", obs.size());
    end
    if (last_seen != 1) begin
      n_bad++;
      $display("FAIL bp_last: got %0d want 1", last_seen);
    end
  endtask

  task automatic test_reset_midflight();
    obs.delete();
    for (int i = 0; i < 3; i++) send(32'd0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || zero_count !== 16'd0) begin
      n_bad++;
      $display("FAIL midrst: got v=%0b zc=%0d want v=0 zc=0", out_valid, zero_count);
    end
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    send(32'd48, 1'b1);
    drain();
    n_cmp++;
    if (obs.size() != 1 || obs[0] != 1430) begin
      n_bad++;
      $display("FAIL midrst_first: got n=%0d d=%0d want n=1 d=1430", obs.size(), obs.size() > 0 ? obs[0] : 0);
    end
  endtask

  task automatic test_zero_sat();
    obs.delete();
    for (int i = 0; i < 70000; i++) send(32'd0, i == 69999);
    drain();
    n_cmp += 2;
    if (zero_count !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL zc_sat: got %0d want 65535", zero_count);
    end
    if (obs.size() != 70000) begin
      n_bad++;
      $display("FAIL zero_count_out: got %0d want 70000", obs.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interp();
    test_back_to_back();
    test_stall();
    test_backpressure();
    test_reset_midflight();
    test_zero_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
